cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
// - Run/halt/single-step sequencer for the pipelined CPU. Sits between the board top level (KEY/SW) and CPU.
// - Holds the CPU in reset after power-up and gates CPU progress through a clock enable.
// - Stops the CPU on a PC breakpoint or when the program-end address is reached.
// - Counts executed (enabled) cycles for display on HEX.
// PARAMETERS
// - PC_W             64       width of the CPU program counter
// - RST_CYCLES       4        cycles cpu_rst is held in BOOT (>=1)
// - DEBOUNCE_CYCLES  500000   consecutive stable samples needed to accept a step-key level change (>=2)
// - CNT_W            32       width of cycle_count
// PORTS
// - clk          in   1      system clock (divided clock feeding the CPU)
// - reset        in   1      asynchronous, active-low reset
// - run_sw       in   1      raw switch, 1 = run freely; asynchronous to clk
// - step_key_n   in   1      raw push button, active-low (0 = pressed); asynchronous, bouncy
// - bkpt_en      in   1      breakpoint compare enable
// - bkpt_addr    in   PC_W   breakpoint PC value
// - end_addr     in   PC_W   first PC past the program; pc >= end_addr means done
// - pc           in   PC_W   current CPU fetch PC
// - cpu_en       out  1      CPU pipeline advance enable (combinational from state + hits)
// - cpu_rst      out  1      active-high reset to the CPU
// - halted       out  1      1 in HALT
// - done         out  1      1 in DONE
// - cycle_count  out  CNT_W  number of cycles with cpu_en=1 since last BOOT, saturating
// BEHAVIOUR
// - Async reset (reset=0): state=BOOT, boot counter=0, cpu_rst=1, cpu_en=0, halted=0, done=0, cycle_count=0, sync/debounce regs to "released".
// - run_sw: 2-FF synchroniser -> run_s. Level only; no debounce.
// - step_key_n: 2-FF synchroniser, then debouncer. Accepted level changes only after DEBOUNCE_CYCLES equal consecutive samples.
// - step_key_n: an accepted 1->0 change produces step_p, a one-cycle pulse. Release produces nothing.
// - Hit terms, combinational:
//   - end_hit = (pc >= end_addr), unsigned compare.
//   - bkpt_hit = bkpt_en && pc == bkpt_addr && armed.
//   - armed is a flag cleared on every entry to RUN and set after the first RUN cycle. This lets execution resume from a breakpoint.
// - States (enum in package), transitions in priority order:
//   - BOOT: cpu_rst=1, cpu_en=0. Count RST_CYCLES cycles, then go to RUN if run_s, else HALT. cycle_count cleared.
//   - HALT: cpu_en=0.
//     - end_hit -> DONE.
//     - run_s -> RUN.
//     - step_p -> STEP.
//     - run_s and step_p in the same cycle: RUN wins and the step is dropped.
//   - STEP: cpu_en = !end_hit for exactly this one cycle; then end_hit ? DONE : HALT. A held key gives one step only.
//   - RUN: cpu_en = run_s && !end_hit && !bkpt_hit.
//     - end_hit -> DONE (end_hit beats bkpt_hit in the same cycle).
//     - bkpt_hit -> HALT.
//     - !run_s -> HALT.
//     - In every stop case cpu_en is already 0 in the deciding cycle, so the PC is frozen at the hit address.
//   - DONE: cpu_en=0, done=1. step_p -> BOOT: the CPU is re-reset and the program reruns. run_s is ignored.
// - cycle_count: +1 on each cycle with cpu_en=1. Holds at all-ones (no wrap). Cleared in BOOT.
// - Outputs halted and done are decoded from the registered state. cpu_rst = (state==BOOT).
// - Reset asserted mid-operation: immediate return to BOOT with reset values. No partial step is completed.
// STRUCTURE
// - Package cpu_ctrl_pkg holds:
//   - typedef enum logic [2:0] {BOOT, HALT, STEP, RUN, DONE} run_state_t
//   - default widths PC_W_DEF=64, CNT_W_DEF=32
// - Sub-module key_sync_edge(clk, reset, key_n, press_p), parameter DEBOUNCE_CYCLES. Contains the synchroniser, debounce counter and falling-edge pulse. Reused for other KEYs.
// - Top of this block: run_s synchroniser, state register, boot counter, armed flag, cycle counter, output decode.
// TESTING (DEBOUNCE_CYCLES=4, RST_CYCLES=4 in bench)
// - Reset release, run_sw=0 -> cpu_rst=1 for 4 cycles, then halted=1, cpu_en=0, cycle_count=0.
// - HALT, step_key_n low with 2-cycle bounces then held low 20 cycles -> exactly one cpu_en pulse; cycle_count=1; back to HALT.
// - run_sw=1, bkpt_en=1, bkpt_addr=32, PC advancing by 4 from 0:
//   - cpu_en=0 in the cycle pc==32; HALT next cycle; cycle_count=8.
//   - Then run_sw toggled 0->1: run resumes past 32.
// - RUN, end_addr=64 and bkpt_addr=64 hit together -> DONE (not HALT), done=1; further run_sw changes ignored; step press -> BOOT, cycle_count=0.
// - run_sw and step press in the same HALT cycle -> RUN entered, no STEP state visited.
// - reset=0 asserted mid-RUN at cycle_count=10 -> same cycle: state BOOT, cpu_rst=1, cpu_en=0, cycle_count=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the CPU run/halt/step controller and its key conditioner.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {BOOT, HALT, STEP, RUN, DONE} run_state_t;

  localparam int PC_W_DEF  = 64;
  localparam int CNT_W_DEF = 32;

  // Bits needed for a counter spanning 0 .. n-1 (at least one bit).
  function automatic int ctr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Push-button conditioner: 2-FF synchroniser, debounce down-counter and a one-cycle press pulse.
// Idle level is "released" (key_n=1); releasing the key produces no pulse.
module key_sync_edge
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press_p
);

  localparam int DB_W = ctr_w(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            key_m;
  logic            key_s;
  logic            key_db;
  logic            change;
  logic [DB_W-1:0] db_cnt;

  assign change = (key_s != key_db);

  // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_m   <= 1'b1;
      key_s   <= 1'b1;
      key_db  <= 1'b1;
      db_cnt  <= DB_LOAD;
      press_p <= 1'b0;
    end else begin
      key_m   <= key_n;
      key_s   <= key_m;
      press_p <= 1'b0;
      if (!change) begin
        db_cnt <= DB_LOAD;
      end else if (db_cnt == '0) begin
        key_db  <= key_s;
        db_cnt  <= DB_LOAD;
        press_p <= ~key_s;
      end else begin
        db_cnt <= db_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer between the board keys/switches and the pipelined CPU.
// state | meaning
// BOOT  | CPU held in reset for RST_CYCLES cycles, cycle counter cleared
// HALT  | CPU frozen, waiting for run switch or step press
// STEP  | exactly one enabled cycle
// RUN   | free running until switch off, breakpoint or program end
// DONE  | program end reached; step press reboots
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W            = PC_W_DEF,
  parameter int RST_CYCLES      = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_key_n,
  input  logic             bkpt_en,
  input  logic [PC_W-1:0]  bkpt_addr,
  input  logic [PC_W-1:0]  end_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic             halted,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int BOOT_W = ctr_w(RST_CYCLES);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(RST_CYCLES - 1);

  run_state_t        state;
  run_state_t        state_next;
  logic              run_m;
  logic              run_s;
  logic              step_p;
  logic              armed;
  logic              end_hit;
  logic              bkpt_hit;
  logic [BOOT_W-1:0] boot_cnt;

  key_sync_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_key (
    .clk    (clk),
    .reset  (reset),
    .key_n  (step_key_n),
    .press_p(step_p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_m <= 1'b0;
      run_s <= 1'b0;
    end else begin
      run_m <= run_sw;
      run_s <= run_m;
    end
  end

  assign end_hit  = (pc >= end_addr);
  assign bkpt_hit = bkpt_en && (pc == bkpt_addr) && armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Every stop decision also drops cpu_en in the same cycle, so the PC stays on the hit address.
  always_comb begin
    state_next = state;
    cpu_en     = 1'b0;
    case (state)
      BOOT: begin
        if (boot_cnt == BOOT_LAST) begin
          state_next = run_s ? RUN : HALT;
        end
      end
      HALT: begin
        if (end_hit) begin
          state_next = DONE;
        end else if (run_s) begin
          state_next = RUN;
        end else if (step_p) begin
          state_next = STEP;
        end
      end
      STEP: begin
        cpu_en     = !end_hit;
        state_next = end_hit ? DONE : HALT;
      end
      RUN: begin
        cpu_en = run_s && !end_hit && !bkpt_hit;
        if (end_hit) begin
          state_next = DONE;
        end else if (bkpt_hit || !run_s) begin
          state_next = HALT;
        end
      end
      DONE: begin
        if (step_p) begin
          state_next = BOOT;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      boot_cnt <= '0;
    end else if (state == BOOT && state_next == BOOT) begin
      boot_cnt <= boot_cnt + 1'b1;
    end else begin
      boot_cnt <= '0;
    end
  end

  // Disarmed for the first RUN cycle so execution can leave a breakpoint address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else if (state_next == RUN && state != RUN) begin
      armed <= 1'b0;
    end else if (state == RUN) begin
      armed <= 1'b1;
    end
  end

  // Cleared on the way into BOOT as well, so a reboot from DONE shows zero at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (state == BOOT || state_next == BOOT) begin
      cycle_count <= '0;
    end else if (cpu_en && cycle_count != '1) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  assign cpu_rst = (state == BOOT);
  assign halted  = (state == HALT);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a cycle model checked every cycle plus directed scenarios with literal expectations.
module tb_cpu_run_ctrl;

  localparam int PC_W = 64;
  localparam int CNT_W = 32;
  localparam int RSTC = 4;
  localparam int DB = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             run_sw;
  logic             step_key_n;
  logic             bkpt_en;
  logic [PC_W-1:0]  bkpt_addr;
  logic [PC_W-1:0]  end_addr;
  logic [PC_W-1:0]  pc = '0;
  logic             cpu_en;
  logic             cpu_rst;
  logic             halted;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  cpu_run_ctrl #(
    .PC_W(PC_W), .RST_CYCLES(RSTC), .DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .run_sw(run_sw), .step_key_n(step_key_n),
    .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .end_addr(end_addr), .pc(pc),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst), .halted(halted), .done(done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Stand-in CPU: fetch PC advances by one instruction per enabled cycle.
  always @(posedge clk) begin
    if (cpu_rst) pc <= '0;
    else if (cpu_en) pc <= pc + 64'd4;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_BOOT = 0, M_HALT = 1, M_STEP = 2, M_RUN = 3, M_DONE = 4;
  int          m_mode;
  int          m_boot_left;
  int          m_run_len;
  logic [31:0] m_count;
  bit   [1:0]  rpipe;
  bit   [1:0]  kpipe;
  bit          m_level;
  bit          m_step;
  bit          hist[$];

  task automatic model_reset();
    m_mode = M_BOOT; m_boot_left = RSTC; m_run_len = 0; m_count = '0;
    rpipe = 2'b00; kpipe = 2'b11; m_level = 1'b1; m_step = 1'b0;
    hist.delete();
  endtask

  always @(negedge clk) begin : model_blk
    bit ks, run_s, end_hit, bkpt_hit, e_en, all_same;
    int nxt;
    cyc++;
    if (!reset) model_reset();
    run_s    = rpipe[1];
    end_hit  = (pc >= end_addr);
    bkpt_hit = bkpt_en && (pc == bkpt_addr) && (m_run_len > 0);
    case (m_mode)
      M_STEP:  e_en = !end_hit;
      M_RUN:   e_en = run_s && !end_hit && !bkpt_hit;
      default: e_en = 1'b0;
    endcase
    chk("cpu_rst", cpu_rst, 64'(m_mode == M_BOOT));
    chk("cpu_en", cpu_en, 64'(e_en));
    chk("halted", halted, 64'(m_mode == M_HALT));
    chk("done", done, 64'(m_mode == M_DONE));
    chk("cycle_count", cycle_count, 64'(m_count));
    if (reset) begin
      nxt = m_mode;
      case (m_mode)
        M_BOOT: begin
          m_boot_left--;
          if (m_boot_left == 0) nxt = run_s ? M_RUN : M_HALT;
        end
        M_HALT: if (end_hit) nxt = M_DONE; else if (run_s) nxt = M_RUN; else if (m_step) nxt = M_STEP;
        M_STEP: nxt = end_hit ? M_DONE : M_HALT;
        M_RUN:  if (end_hit) nxt = M_DONE; else if (bkpt_hit || !run_s) nxt = M_HALT;
        M_DONE: if (m_step) begin nxt = M_BOOT; m_boot_left = RSTC; end
        default: nxt = M_BOOT;
      endcase
      if (nxt == M_BOOT) m_count = '0;
      else if (e_en && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      if (nxt == M_RUN) m_run_len = (m_mode == M_RUN) ? m_run_len + 1 : 0;
      m_mode = nxt;
      // key accepted once the last DB synchronised samples agree on a new level
      ks = kpipe[1];
      hist.push_back(ks);
      if (hist.size() > DB) void'(hist.pop_front());
      m_step = 1'b0;
      if (hist.size() == DB && ks != m_level) begin
        all_same = 1'b1;
        foreach (hist[i]) if (hist[i] != ks) all_same = 1'b0;
        if (all_same) begin
          m_level = ks;
          m_step  = !ks;
        end
      end
      rpipe = {rpipe[0], run_sw};
      kpipe = {kpipe[0], step_key_n};
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key_hold(input bit lvl, input int len, inout int pulses);
    step_key_n = lvl;
    repeat (len) begin
      @(negedge clk);
      if (cpu_en) pulses++;
      @(posedge clk);
      #1;
    end
  endtask

  bit pat_lvl[10];
  int pat_len[10];

  initial begin
    int n;
    bit found;
    pat_lvl = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    pat_len = '{2, 2, 2, 2, 2, 2, 2, 2, 20, 12};
    reset = 1'b0; run_sw = 1'b0; step_key_n = 1'b1; bkpt_en = 1'b0;
    bkpt_addr = '0; end_addr = 64'd1000;

    // reset release with run off: BOOT for RSTC cycles, then HALT
    tick(3);
    @(negedge clk);
    chk("in_reset_cpu_rst", cpu_rst, 1);
    chk("in_reset_cpu_en", cpu_en, 0);
    tick(1);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_rst) n++;
    end
    chk("boot_len", n, 4);
    chk("boot_halted", halted, 1);
    chk("boot_cpu_en", cpu_en, 0);
    chk("boot_count", cycle_count, 0);

    // bouncy step press: one enabled cycle only
    tick(1);
    n = 0;
    for (int i = 0; i < 10; i++) key_hold(pat_lvl[i], pat_len[i], n);
    chk("step_pulses", n, 1);
    chk("step_count", cycle_count, 1);
    chk("step_pc", pc, 4);
    chk("step_back_halted", halted, 1);

    // breakpoint at 32 while running
    reset = 1'b0; bkpt_en = 1'b1; bkpt_addr = 64'd32; run_sw = 1'b1;
    tick(2);
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (pc == 64'd32) found = 1'b1;
    end
    chk("bkpt_reached", 64'(found), 1);
    chk("bkpt_cpu_en", cpu_en, 0);
    chk("bkpt_count", cycle_count, 8);
    @(negedge clk);
    chk("bkpt_halted", halted, 1);
    tick(1);
    run_sw = 1'b0;
    tick(8);
    chk("stop_halted", halted, 1);
    chk("stop_pc", pc, 40);
    run_sw = 1'b1;
    tick(8);
    chk("resume_past_bkpt", 64'(pc > 64'd40), 1);

    // end and breakpoint on the same address: end wins
    reset = 1'b0; bkpt_addr = 64'd64; end_addr = 64'd64;
    tick(2);
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (pc == 64'd64) found = 1'b1;
    end
    chk("end_reached", 64'(found), 1);
    chk("end_cpu_en", cpu_en, 0);
    chk("end_count", cycle_count, 16);
    @(negedge clk);
    chk("end_done", done, 1);
    chk("end_not_halted", halted, 0);
    tick(1);
    run_sw = 1'b0;
    tick(6);
    run_sw = 1'b1;
    tick(6);
    chk("done_ignores_run", done, 1);
    chk("done_pc_frozen", pc, 64);
    run_sw = 1'b0;
    step_key_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cpu_rst) found = 1'b1;
    end
    chk("reboot_seen", 64'(found), 1);
    chk("reboot_count", cycle_count, 0);
    tick(1);
    step_key_n = 1'b1;
    tick(12);
    chk("reboot_halted", halted, 1);
    chk("reboot_pc", pc, 0);

    // run switch and step pulse land in the same HALT cycle
    end_addr = 64'd1000; bkpt_en = 1'b0;
    tick(2);
    step_key_n = 1'b0;
    tick(4);
    run_sw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!halted) found = 1'b1;
    end
    chk("race_left_halt", 64'(found), 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (!halted && cpu_en) n++;
      if (i < 4) @(negedge clk);
    end
    chk("race_run_cycles", n, 5);
    tick(1);
    step_key_n = 1'b1;

    // asynchronous reset mid-run
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (cycle_count == 32'd9 && cpu_en) found = 1'b1;
    end
    chk("mid_run_reached", 64'(found), 1);
    tick(1);
    chk("pre_reset_count", cycle_count, 10);
    reset = 1'b0;
    #1;
    chk("async_cpu_rst", cpu_rst, 1);
    chk("async_cpu_en", cpu_en, 0);
    chk("async_count", cycle_count, 0);
    chk("async_halted", halted, 0);
    chk("async_done", done, 0);
    tick(2);
    reset = 1'b1;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
